uart_tx_cfg: RTL
================

// Module: uart_tx_cfg
// PURPOSE
//  Parametrised UART transmitter, successor to the fixed 8N1 tx. Serialises one
//  DATA_W-bit word per frame with optional parity and 1/2 stop bits, timed by
//  the shared baud oversample tick t_gen. Sits between the calculator result
//  formatter (valid/ready source) and the board TXD pin.
// PARAMETERS
//  DATA_W     8   data bits per frame, legal 5..8, sent LSB first
//  OVS        16  t_gen ticks per bit, legal 4..32
//  PARITY     0   0 = none, 1 = even, 2 = odd
//  STOP_BITS  1   stop bits, legal 1 or 2
// PORTS
//  clk         in   1        system clock, all logic on rising edge
//  rst         in   1        asynchronous reset, active-high
//  t_gen       in   1        oversample tick, 1-clk pulse, OVS per bit period
//  u_out       in   DATA_W   word to send, sampled only on accept
//  u_valid     in   1        source has a word on u_out
//  u_ready     out  1        block can accept; high only in IDLE
//  txd         out  1        serial line, idle high
//  busy        out  1        frame in progress (state != IDLE)
//  frame_done  out  1        1-clk pulse when the last stop bit completes
// BEHAVIOUR
//  Reset (async, immediate): state=IDLE, txd=1, u_ready=1, busy=0,
//   frame_done=0, tick/bit counters=0, shift reg=0. Reset mid-frame aborts the
//   frame; the word is dropped, never resumed.
//  Accept: u_valid & u_ready on a clk edge -> latch u_out, compute parity
//   (even: ^data, odd: ~^data), go START, clear tick counter. u_out changes
//   after accept have no effect.
//  FSM: IDLE -> START -> DATA -> [PARITY if PARITY!=0] -> STOP -> IDLE.
//   txd is registered: 0 in START, shift[0] in DATA, parity bit in PARITY,
//   1 in STOP and IDLE. txd changes on the edge that enters the state.
//  Bit timing: tick counter increments on each t_gen while busy; when it
//   reaches OVS-1 with t_gen high, the bit ends: counter -> 0, advance.
//   t_gen ignored in IDLE. Absent t_gen, txd holds indefinitely.
//  DATA: DATA_W bits; bit counter 0..DATA_W-1, shift right after each bit.
//  STOP: STOP_BITS bit periods of txd=1 (bit counter reused).
//  Completion: on the tick ending the last stop bit -> IDLE; frame_done=1 and
//   u_ready=1 for that one cycle. Frame = OVS*(1+DATA_W+(PARITY!=0)+STOP_BITS)
//   t_gen ticks.
//  Back-to-back: if u_valid is high in the first IDLE cycle, the next word is
//   accepted there; new start bit begins the following edge (1 clk gap only,
//   no idle bit period inserted).
//  A u_valid held high during a frame is not accepted until IDLE (no
//   duplicate sends, no drops).
//  Illegal parameter values: elaboration-time $error, no runtime behaviour.
// TESTING
//  1. 8N1, OVS=16, t_gen every clk, send 0x55 -> txd: 0 then 1,0,1,0,1,0,1,0
//     then 1, each exactly 16 clk; frame_done at clk 160 after accept.
//  2. PARITY=1, send 0x07 -> parity bit 1; PARITY=2, send 0x00 -> parity
//     bit 1; frame = 11 bit periods.
//  3. DATA_W=7, STOP_BITS=2, send 0x7F -> 7 ones after start, 2 stop periods,
//     10 bit periods total; bit 7 of u_out never appears.
//  4. u_valid held high with 0xA5 then 0x3C -> two frames, 1 clk gap,
//     u_ready high exactly one clk between them, each byte sent once.
//  5. t_gen every 4th clk, OVS=16 -> each bit 64 clk; t_gen held low 100 clk
//     mid-DATA -> txd and counters frozen, frame resumes correctly.
//  6. rst asserted mid-DATA (not on clk edge) -> txd=1, u_ready=1, busy=0
//     immediately; after release next accepted word sends a full clean frame.

Source files
------------

// File: rtl/uart_tx_cfg.sv
// Parametrised UART transmitter: DATA_W data bits LSB first, optional even/odd parity,
// 1 or 2 stop bits, each bit lasting OVS pulses of the shared oversample tick t_gen.
module uart_tx_cfg #(
   parameter int unsigned DATA_W    = 8,
   parameter int unsigned OVS       = 16,
   parameter int unsigned PARITY    = 0,
   parameter int unsigned STOP_BITS = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              t_gen,
   input  logic [DATA_W-1:0] u_out,
   input  logic              u_valid,
   output logic              u_ready,
   output logic              txd,
   output logic              busy,
   output logic              frame_done
);

   if (DATA_W < 5 || DATA_W > 8) begin : g_bad_data_w
      $error("uart_tx_cfg: DATA_W must be 5..8");
   end
   if (OVS < 4 || OVS > 32) begin : g_bad_ovs
      $error("uart_tx_cfg: OVS must be 4..32");
   end
   if (PARITY > 2) begin : g_bad_parity
      $error("uart_tx_cfg: PARITY must be 0, 1 or 2");
   end
   if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
      $error("uart_tx_cfg: STOP_BITS must be 1 or 2");
   end

   localparam int unsigned TW = $clog2(OVS);
   localparam int unsigned BW = 3;

   typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

   state_e              state_q, state_d;
   logic [TW-1:0]       tick_q, tick_d;
   logic [BW-1:0]       bit_q, bit_d;
   logic [DATA_W-1:0]   shift_q, shift_d;
   logic                par_q, par_d;
   logic                txd_q, txd_d;
   logic                done_q, done_d;
   logic                bit_end;

   always_comb begin
      state_d = state_q;
      tick_d  = tick_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      par_d   = par_q;
      done_d  = 1'b0;
      bit_end = t_gen && (tick_q == TW'(OVS - 1));

      if (state_q != StIdle && t_gen) begin
         tick_d = bit_end ? '0 : tick_q + TW'(1);
      end

      case (state_q)
         StIdle: begin
            if (u_valid) begin
               shift_d = u_out;
               par_d   = (PARITY == 2) ? ~^u_out : ^u_out;
               tick_d  = '0;
               bit_d   = '0;
               state_d = StStart;
            end
         end
         StStart: begin
            if (bit_end) begin
               bit_d   = '0;
               state_d = StData;
            end
         end
         StData: begin
            if (bit_end) begin
               shift_d = shift_q >> 1;
               if (bit_q == BW'(DATA_W - 1)) begin
                  bit_d   = '0;
                  state_d = (PARITY != 0) ? StParity : StStop;
               end else begin
                  bit_d = bit_q + BW'(1);
               end
            end
         end
         StParity: begin
            if (bit_end) begin
               bit_d   = '0;
               state_d = StStop;
            end
         end
         StStop: begin
            if (bit_end) begin
               if (bit_q == BW'(STOP_BITS - 1)) begin
                  bit_d   = '0;
                  done_d  = 1'b1;
                  state_d = StIdle;
               end else begin
                  bit_d = bit_q + BW'(1);
               end
            end
         end
         default: state_d = StIdle;
      endcase

      // txd is registered from the state being entered, so it changes on the entering edge
      case (state_d)
         StStart:  txd_d = 1'b0;
         StData:   txd_d = shift_d[0];
         StParity: txd_d = par_d;
         default:  txd_d = 1'b1;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         tick_q  <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         par_q   <= 1'b0;
         txd_q   <= 1'b1;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         tick_q  <= tick_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         par_q   <= par_d;
         txd_q   <= txd_d;
         done_q  <= done_d;
      end
   end

   assign txd        = txd_q;
   assign frame_done = done_q;
   assign busy       = (state_q != StIdle);
   assign u_ready    = (state_q == StIdle);

endmodule
